uart_tx_fifo: RTL and testbench

- 8N1 UART transmitter with a small transmit FIFO and a programmable bit-period divider.
- Drives a serial line that an external UART receiver or the testbench UART monitor samples.
- Firmware-facing logic pushes bytes through a valid/ready handshake.
- The block serialises the bytes LSB-first, with start and stop framing.

---
 rtl/uart_tx_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo_buf: circular byte FIFO with registered occupancy count.
// Latency: a written entry is offered to the reader two edges after the write edge.
// Backpressure: wr_rdy drops at full and stays low during reset; rd_vld is gated by occupancy.
//   clk, resetn      - clock, async active-low reset
//   wr_vld/wr_dat/wr_rdy - write handshake
//   rd_vld/rd_rdy/rd_dat - read handshake (rd_dat is the head entry)
//   level            - registered occupancy
module uart_tx_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             en_q;
  logic             avail_q;
  logic             push;
  logic             pop;

  // en_q keeps the write side closed while in reset and opens it on the first clock after.
  assign wr_rdy = en_q && (level_q != (AW+1)'(DEPTH));
  // avail_q is the occupancy seen one clock late: a fresh write settles in memory before
  // the reader may take it. The level term masks the stale cycle right after a pop.
  assign rd_vld = avail_q && (level_q != '0);
  assign rd_dat = mem[rd_ptr_q];
  assign level  = level_q;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      en_q     <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      avail_q <= (level_q != '0);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// Latency: ser_tx falls on the 2nd edge after the accepting edge; frame = (9+STOP_BITS)*eff_div clocks.
// Backpressure: tx_ready = registered "FIFO not full"; a held tx_valid waits, nothing dropped.
//   clk, resetn  - clock, async active-low reset
//   cfg_div      - clocks per bit (0/1 act as 2), sampled at frame start
//   tx_data/tx_valid/tx_ready - byte input handshake
//   ser_tx       - serial line, idle high
//   busy         - frame in progress or bytes queued
//   fifo_level   - FIFO occupancy
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        ser_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] eff_div_q, eff_div_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 ser_q, ser_d;

  logic                 fifo_vld;
  logic [7:0]           fifo_dat;
  logic                 pop;
  logic                 launch;
  logic                 bit_end;
  logic [DIV_WIDTH-1:0] cfg_eff;

  uart_tx_fifo_buf #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_vld (tx_valid),
    .wr_dat (tx_data),
    .wr_rdy (tx_ready),
    .rd_vld (fifo_vld),
    .rd_rdy (pop),
    .rd_dat (fifo_dat),
    .level  (fifo_level)
  );

  assign cfg_eff = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
  assign bit_end = (div_cnt_q == eff_div_q - DIV_WIDTH'(1));
  assign ser_tx  = ser_q;
  assign busy    = (state_q != IDLE) || (fifo_level != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_cnt_q <= '0;
      eff_div_q <= DIV_WIDTH'(2);
      bit_cnt_q <= '0;
      ser_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_cnt_q <= div_cnt_d;
      eff_div_q <= eff_div_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_cnt_d = div_cnt_q;
    eff_div_d = eff_div_q;
    bit_cnt_d = bit_cnt_q;
    ser_d     = ser_q;
    launch    = 1'b0;
    pop       = 1'b0;

    if (state_q != IDLE) div_cnt_d = bit_end ? '0 : div_cnt_q + DIV_WIDTH'(1);

    case (state_q)
      IDLE: launch = fifo_vld;
      START: begin
        if (bit_end) begin
          ser_d     = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            ser_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            ser_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_cnt counts stop bits here; the last one may chain straight into a new frame.
        if (bit_end) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            launch    = fifo_vld;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: take the head byte and freeze the bit period for the whole frame.
    if (launch) begin
      pop       = 1'b1;
      shift_d   = fifo_dat;
      eff_div_d = cfg_eff;
      ser_d     = 1'b0;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      state_d   = START;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scenario tasks drive bytes and push the expected frames to a queue;
// a line monitor decodes ser_tx cycle by cycle and pops/compares each completed frame.
// Default parameters: FIFO_DEPTH 4, STOP_BITS 1, DIV_WIDTH 16.
module tb_uart_tx_fifo;
  localparam int STOP_BITS = 1;
  localparam int NBITS     = 9 + STOP_BITS;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [15:0] cfg_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ser_tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_hs  = 0;
  bit   mon_busy = 0;
  exp_t sb_q[$];
  int   start_q[$];

  uart_tx_fifo #(
    .FIFO_DEPTH (4),
    .STOP_BITS  (STOP_BITS),
    .DIV_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_div    (cfg_div),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: every sample of a frame is compared with the expected level, so bit
  // lengths, ordering and stop timing are all checked, not only the decoded byte.
  initial begin : uart_monitor
    exp_t       e;
    logic [7:0] got;
    logic       lvl;
    logic       bad_act;
    logic       bad_req;
    int         bad_c;
    int         idx;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && ser_tx === 1'b0) begin
        start_q.push_back(cyc);
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_start cycle %0d: line low with nothing queued, required idle high", cyc);
        end else begin
          n_pass++;
          e        = sb_q[0];
          mon_busy = 1'b1;
          got      = '0;
          bad_c    = -1;
          bad_act  = 1'b0;
          bad_req  = 1'b0;
          aborted  = 1'b0;
          for (int c = 0; c < NBITS * e.div; c++) begin
            if (c > 0) @(negedge clk);
            if (resetn !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            idx = c / e.div;
            lvl = (idx == 0) ? 1'b0 : (idx >= 9) ? 1'b1 : e.data[idx-1];
            if (ser_tx !== lvl && bad_c < 0) begin
              bad_c   = c;
              bad_act = ser_tx;
              bad_req = lvl;
            end
            if (idx >= 1 && idx <= 8 && (c % e.div) == e.div / 2) got[idx-1] = ser_tx;
          end
          if (!aborted) begin
            void'(sb_q.pop_front());
            n_checks++;
            if (bad_c >= 0)
              $display("FAIL frame_shape byte %02h div %0d: clock %0d of frame is %b, required %b",
                       e.data, e.div, bad_c, bad_act, bad_req);
            else n_pass++;
            n_checks++;
            if (got !== e.data) $display("FAIL frame_byte: decoded %02h, required %02h", got, e.data);
            else n_pass++;
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with tx_valid low.
  task automatic push(input logic [7:0] d, input int div);
    int t;
    t        = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL push_timeout byte %02h: tx_ready %b, required 1", d, tx_ready);
    end else begin
      sb_q.push_back('{d, div});
      last_hs = cyc + 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || mon_busy || busy === 1'b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b1 && mon_busy || busy !== 1'b0)
      $display("FAIL %s_drain: %0d frames outstanding, busy %b, required 0 and 0", name, sb_q.size(), busy);
    else n_pass++;
  endtask

  task automatic wait_start(input int n);
    int t;
    t = 0;
    while (start_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset;
    resetn   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    cfg_div  = 16'd4;
    #1 resetn = 1'b0;
    #2;
    n_checks++;
    if (ser_tx !== 1'b1) $display("FAIL reset_ser_tx: %b, required 1", ser_tx); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: %b, required 0", tx_ready); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL reset_busy_level: busy %b level %0d, required 0 0", busy, fifo_level);
    else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1) $display("FAIL reset_release_ready: %b, required 1", tx_ready); else n_pass++;
  endtask

  task automatic test_single;
    int t;
    start_q.delete();
    cfg_div = 16'd4;
    push(8'h55, 4);
    wait_start(1);
    n_checks++;
    if (start_q.size() != 1 || start_q[0] != last_hs + 2)
      $display("FAIL single_latency: start cycle %0d, required %0d", start_q.size() ? start_q[0] : -1, last_hs + 2);
    else n_pass++;
    t = 0;
    while (busy === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (start_q.size() == 0 || cyc != start_q[0] + 40)
      $display("FAIL single_busy_drop: cycle %0d, required %0d", cyc, start_q.size() ? start_q[0] + 40 : -1);
    else n_pass++;
    n_checks++;
    if (ser_tx !== 1'b1) $display("FAIL single_idle_line: %b, required 1", ser_tx); else n_pass++;
    wait_drain("single");
  endtask

  task automatic test_back_to_back;
    start_q.delete();
    cfg_div = 16'd5;
    push(8'h48, 5);
    push(8'h69, 5);
    push(8'h0a, 5);
    wait_drain("b2b");
    n_checks++;
    if (start_q.size() != 3 || start_q[1] - start_q[0] != 50 || start_q[2] - start_q[1] != 50)
      $display("FAIL b2b_gap: %0d frames, spacing %0d/%0d, required 3 frames spaced 50/50", start_q.size(),
               start_q.size() > 1 ? start_q[1] - start_q[0] : -1, start_q.size() > 2 ? start_q[2] - start_q[1] : -1);
    else n_pass++;
  endtask

  task automatic test_full;
    bit saw_full;
    int t;
    int bad;
    start_q.delete();
    cfg_div  = 16'd8;
    saw_full = 0;
    bad      = 0;
    for (int b = 1; b <= 6; b++) begin
      tx_data  = 8'(b);
      tx_valid = 1'b1;
      t        = 0;
      while (tx_ready !== 1'b1 && t < 3000) begin
        if (fifo_level === 3'd4) saw_full = 1;
        if (tx_ready !== (fifo_level != 3'd4)) bad++;
        @(negedge clk);
        t++;
      end
      if (tx_ready === 1'b1) begin
        if (fifo_level === 3'd4) bad++;
        sb_q.push_back('{8'(b), 8});
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    n_checks++;
    if (!saw_full) $display("FAIL full_reached: full with ready low seen %0d, required 1", saw_full); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL full_ready: %0d cycles where tx_ready disagreed with level, required 0", bad);
    else n_pass++;
    wait_drain("full");
    n_checks++;
    if (start_q.size() != 6) $display("FAIL full_count: %0d frames, required 6", start_q.size()); else n_pass++;
  endtask

  task automatic test_div_clamp;
    start_q.delete();
    cfg_div = 16'd0;
    push(8'hA3, 2);
    wait_drain("clamp");
    n_checks++;
    if (start_q.size() != 1) $display("FAIL clamp_count: %0d frames, required 1", start_q.size()); else n_pass++;
  endtask

  task automatic test_div_change;
    int t;
    start_q.delete();
    cfg_div = 16'd6;
    push(8'hF0, 6);
    wait_start(1);
    t = 0;
    while (start_q.size() > 0 && cyc < start_q[0] + 20 && t < 200) begin
      @(negedge clk);
      t++;
    end
    cfg_div = 16'd3;
    push(8'h0F, 3);
    wait_drain("divchg");
    n_checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 60)
      $display("FAIL divchg_spacing: %0d frames, spacing %0d, required 2 frames spaced 60", start_q.size(),
               start_q.size() > 1 ? start_q[1] - start_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int t;
    start_q.delete();
    cfg_div = 16'd4;
    push(8'hC3, 4);
    push(8'h11, 4);
    push(8'h22, 4);
    wait_start(1);
    t = 0;
    while (start_q.size() > 0 && cyc < start_q[0] + 21 && t < 200) begin
      @(negedge clk);
      t++;
    end
    #1 resetn = 1'b0;
    #2;
    n_checks++;
    if (ser_tx !== 1'b1) $display("FAIL midreset_ser_tx: %b, required 1", ser_tx); else n_pass++;
    n_checks++;
    if (fifo_level !== 3'd0 || busy !== 1'b0)
      $display("FAIL midreset_flush: level %0d busy %b, required 0 0", fifo_level, busy);
    else n_pass++;
    sb_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL midreset_release: ready %b busy %b, required 1 0", tx_ready, busy);
    else n_pass++;
    start_q.delete();
    push(8'h7E, 4);
    wait_drain("midreset");
    n_checks++;
    if (start_q.size() != 1) $display("FAIL midreset_count: %0d frames, required 1", start_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_div_clamp();
    test_div_change();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
